// File: rtl/alu_wide_sequencer.sv
// Drives the 8-bit Alu one byte per cycle, LSB first, to perform an NBYTES-wide
// operation with carry/borrow chained between bytes and a wide zero flag.
module alu_wide_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic                  cin,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry,
    output logic                  zero,
    output logic [7:0]            alu_in1,
    output logic [7:0]            alu_in2,
    output logic                  alu_cin,
    output logic [2:0]            alu_opcode,
    input  logic [7:0]            alu_out,
    input  logic                  alu_zero,
    input  logic                  alu_cout
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    localparam logic [2:0] ADD_FN  = 3'd0;
    localparam logic [2:0] ADDC_FN = 3'd1;
    localparam logic [2:0] SUB_FN  = 3'd2;
    localparam logic [2:0] SUBC_FN = 3'd3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic [8*NBYTES-1:0]   a_q;
    logic [8*NBYTES-1:0]   b_q;
    logic [2:0]            op_q;
    logic                  carry_q;
    logic                  zacc;

    logic                  is_add;
    logic                  is_sub;
    logic                  borrow_next;
    logic                  carry_next;

    assign is_add = (op_q == ADD_FN) || (op_q == ADDC_FN);
    assign is_sub = (op_q == SUB_FN) || (op_q == SUBC_FN);

    // The Alu has no borrow output, so the sub chain derives it from the byte operands.
    assign borrow_next = ({1'b0, alu_in1} < ({1'b0, alu_in2} + {8'd0, carry_q}));
    assign carry_next  = is_add ? alu_cout : (is_sub ? borrow_next : 1'b0);

    always_comb begin
        alu_in1    = 8'd0;
        alu_in2    = 8'd0;
        alu_cin    = 1'b0;
        alu_opcode = ADD_FN;
        if (state == RUN) begin
            alu_in1 = a_q[8*idx +: 8];
            alu_in2 = b_q[8*idx +: 8];
            alu_cin = carry_q;
            if (is_add)
                alu_opcode = (idx == '0 && op_q == ADD_FN) ? ADD_FN : ADDC_FN;
            else if (is_sub)
                alu_opcode = (idx == '0 && op_q == SUB_FN) ? SUB_FN : SUBC_FN;
            else
                alu_opcode = op_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= ADD_FN;
            carry_q <= 1'b0;
            zacc    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        idx     <= '0;
                        carry_q <= (op == ADDC_FN || op == SUBC_FN) ? cin : 1'b0;
                        zacc    <= 1'b1;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    result[8*idx +: 8] <= alu_out;
                    zacc    <= zacc & alu_zero;
                    carry_q <= carry_next;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        carry <= carry_next;
                        zero  <= zacc & alu_zero;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer with a behavioural 8-bit Alu and a
// scoreboard of wide results computed directly from the operands.
module tb_alu_wide_sequencer;

    localparam int NBYTES = 4;
    localparam int W = 8 * NBYTES;

    localparam logic [2:0] ADD_FN  = 3'd0;
    localparam logic [2:0] ADDC_FN = 3'd1;
    localparam logic [2:0] SUB_FN  = 3'd2;
    localparam logic [2:0] SUBC_FN = 3'd3;
    localparam logic [2:0] AND_FN  = 3'd4;
    localparam logic [2:0] OR_FN   = 3'd5;
    localparam logic [2:0] XOR_FN  = 3'd6;
    localparam logic [2:0] MASK_FN = 3'd7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic          cin;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry;
    logic          zero;
    logic [7:0]    alu_in1;
    logic [7:0]    alu_in2;
    logic          alu_cin;
    logic [2:0]    alu_opcode;
    logic [7:0]    alu_out;
    logic          alu_zero;
    logic          alu_cout;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   total_count = 0;
    int   pass_count  = 0;

    alu_wide_sequencer #(.NBYTES(NBYTES)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    // Byte Alu model; cout is forced high for non-add ops so a misused cout shows up.
    always_comb begin
        logic [8:0] s;
        s = 9'd0;
        case (alu_opcode)
            ADD_FN:  s = {1'b0, alu_in1} + {1'b0, alu_in2};
            ADDC_FN: s = {1'b0, alu_in1} + {1'b0, alu_in2} + {8'd0, alu_cin};
            SUB_FN:  s = {1'b1, alu_in1 - alu_in2};
            SUBC_FN: s = {1'b1, alu_in1 - alu_in2 - {7'd0, alu_cin}};
            AND_FN:  s = {1'b1, alu_in1 & alu_in2};
            OR_FN:   s = {1'b1, alu_in1 | alu_in2};
            XOR_FN:  s = {1'b1, alu_in1 ^ alu_in2};
            default: s = {1'b1, alu_in1 & ~alu_in2};
        endcase
        alu_out  = s[7:0];
        alu_cout = s[8];
        alu_zero = (s[7:0] == 8'd0);
    end

    task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total_count++;
        assert (obs === exp) pass_count++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t wide_model(input logic [2:0] o, input logic [W-1:0] x,
                                        input logic [W-1:0] y, input logic ci);
        exp_t e;
        logic [W:0] w;
        e.c = 1'b0;
        case (o)
            ADD_FN:  begin w = {1'b0, x} + {1'b0, y}; e.res = w[W-1:0]; e.c = w[W]; end
            ADDC_FN: begin w = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci}; e.res = w[W-1:0]; e.c = w[W]; end
            SUB_FN:  begin e.res = x - y; e.c = (x < y); end
            SUBC_FN: begin e.res = x - y - {{(W-1){1'b0}}, ci};
                           e.c = ({1'b0, x} < ({1'b0, y} + {{W{1'b0}}, ci})); end
            AND_FN:  e.res = x & y;
            OR_FN:   e.res = x | y;
            XOR_FN:  e.res = x ^ y;
            default: e.res = x & ~y;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    function automatic logic [2:0] first_opcode(input logic [2:0] o);
        return o;
    endfunction

    function automatic logic [2:0] later_opcode(input logic [2:0] o);
        if (o == ADD_FN || o == ADDC_FN) return ADDC_FN;
        if (o == SUB_FN || o == SUBC_FN) return SUBC_FN;
        return o;
    endfunction

    // One wide op; optionally re-pulses start mid-RUN with different operands.
    task automatic apply_stimulus(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic ci, input bit repulse);
        exp_t e;
        int   seen_at;
        sb.push_back(wide_model(o, x, y, ci));
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; cin = ci;
        @(posedge clk); #1;
        start = 1'b0;
        check_output({tag, "_in1_b0"}, W'(alu_in1), W'(x[7:0]));
        check_output({tag, "_opc_b0"}, W'(alu_opcode), W'(first_opcode(o)));
        seen_at = 0;
        for (int n = 1; n <= NBYTES + 4; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                check_output({tag, "_in2_b1"}, W'(alu_in2), W'(y[15:8]));
                check_output({tag, "_opc_b1"}, W'(alu_opcode), W'(later_opcode(o)));
                if (repulse) begin
                    start = 1'b1; op = SUB_FN; a = '1; b = 32'h1234; cin = 1'b1;
                end
            end
            if (n == 2) start = 1'b0;
            if (done) begin
                seen_at = n;
                break;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        check_output({tag, "_done_latency"}, W'(seen_at), W'(NBYTES));
        check_output({tag, "_result"}, result, e.res);
        check_output({tag, "_carry"}, W'(carry), W'(e.c));
        check_output({tag, "_zero"}, W'(zero), W'(e.z));
        check_output({tag, "_busy_at_done"}, W'(busy), W'(1));
        @(posedge clk); #1;
        check_output({tag, "_done_pulse"}, W'(done), W'(0));
        check_output({tag, "_busy_after"}, W'(busy), W'(0));
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; op = ADD_FN; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_busy", W'(busy), W'(0));
        check_output("rst_done", W'(done), W'(0));
        check_output("rst_result", result, '0);
        check_output("rst_carry", W'(carry), W'(0));
        check_output("rst_zero", W'(zero), W'(0));
        check_output("rst_alu_opc", W'(alu_opcode), W'(ADD_FN));
        check_output("rst_alu_in1", W'(alu_in1), W'(0));
        @(negedge clk); rst = 1'b0;

        apply_stimulus("add_ff", ADD_FN, 32'h000000FF, 32'h00000001, 1'b0, 0);
        apply_stimulus("add_wrap", ADD_FN, 32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
        apply_stimulus("addc", ADDC_FN, 32'h12345678, 32'h11111111, 1'b1, 0);
        apply_stimulus("sub", SUB_FN, 32'h00000000, 32'h00000001, 1'b1, 0);
        apply_stimulus("subc", SUBC_FN, 32'h00000100, 32'h00000000, 1'b1, 0);
        apply_stimulus("xor", XOR_FN, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 0);
        apply_stimulus("mask", MASK_FN, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        apply_stimulus("or", OR_FN, 32'h00F00000, 32'h0000000F, 1'b1, 0);
        apply_stimulus("and", AND_FN, 32'hF0F0FFFF, 32'h3C3C0000, 1'b0, 0);
        apply_stimulus("repulse", ADD_FN, 32'h01020304, 32'h10203040, 1'b0, 1);

        // Reset after two bytes have been written: partial result must vanish.
        @(negedge clk);
        start = 1'b1; op = ADD_FN; a = 32'h01010101; b = 32'h01010101; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("midrst_busy", W'(busy), W'(0));
        check_output("midrst_done", W'(done), W'(0));
        check_output("midrst_result", result, '0);
        check_output("midrst_carry", W'(carry), W'(0));
        check_output("midrst_zero", W'(zero), W'(0));
        check_output("midrst_alu_in1", W'(alu_in1), W'(0));
        rst = 1'b0;
        done_seen = 0;
        repeat (NBYTES + 3) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check_output("midrst_no_done", W'(done_seen), W'(0));

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
